tick_sequencer: RTL
===================

TICK_SEQUENCER -- requirements
Module: tick_sequencer

Interface
REQ-001 The module SHALL have parameter DIV_WIDTH, default 26: width of the period register and the divider.
REQ-002 The module SHALL have parameter CNT_WIDTH, default 16: width of the burst-count register.
REQ-003 Port clk, input, 1 bit: single clock; all logic is on its rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port cfg_valid, input, 1 bit: a configuration word is offered.
REQ-006 Port cfg_ready, output, 1 bit: a configuration word can be accepted.
REQ-007 Port cfg_period, input, DIV_WIDTH bits: tick period in clk cycles.
REQ-008 Port cfg_count, input, CNT_WIDTH bits: ticks per burst; 0 means continuous.
REQ-009 Port start, input, 1 bit: level-sampled request to begin a burst.
REQ-010 Port stop, input, 1 bit: level-sampled request to abort a burst.
REQ-011 Port tick, output, 1 bit: one-cycle strobe, once per period.
REQ-012 Port done, output, 1 bit: one-cycle strobe marking completion of a finite burst.
REQ-013 Port busy, output, 1 bit: high while in RUN.
REQ-014 Port ticks_left, output, CNT_WIDTH bits: ticks remaining in the current burst.

Function
REQ-015 The FSM SHALL have three states: IDLE (no config), LOADED (config held), RUN (generating ticks).
REQ-016 cfg_ready SHALL be high in IDLE and LOADED and low in RUN.
REQ-017 A config SHALL be accepted on an edge where cfg_valid and cfg_ready are both high; it latches period and count, loads ticks_left with cfg_count, and moves to LOADED.
REQ-018 The effective period SHALL be P = max(cfg_period, 1); P=1 gives a tick every cycle.
REQ-019 start SHALL be ignored in IDLE.
REQ-020 start sampled high in LOADED with stop low SHALL enter RUN and clear the divider.
REQ-021 If a config is accepted on the same edge as start, the new config SHALL be used.
REQ-022 In RUN, the divider SHALL count 0..P-1 and wrap; tick SHALL be high for exactly one cycle each time the divider reaches P-1.
REQ-023 The first tick SHALL be high P cycles after the edge that sampled start (P=5: start sampled at edge 0, tick high in cycle 5).
REQ-024 All outputs SHALL be registered; tick, done and busy SHALL have no combinational path from inputs.
REQ-025 For a finite burst (count N>0), ticks_left SHALL decrement by 1 together with each tick.
REQ-026 On the Nth tick, done SHALL be high in the same cycle as that tick, and the FSM SHALL return to LOADED with ticks_left reloaded to N.
REQ-027 For count=0 (continuous), ticks_left SHALL stay 0, done SHALL never assert, and the burst SHALL run until stop.
REQ-028 stop sampled high in RUN SHALL move the FSM to LOADED on that edge, suppress any tick due on the same cycle, assert no done, and reload ticks_left.
REQ-029 When start and stop are both high, stop SHALL win: no RUN entry, or exit from RUN.
REQ-030 stop outside RUN SHALL have no effect.
REQ-031 The divider SHALL wrap modulo P only and SHALL never exceed P-1; period and count registers SHALL never overflow.

Reset
REQ-032 While rst is high, the module SHALL force: state IDLE, tick=0, done=0, busy=0, ticks_left=0, cfg_ready=1, divider=0, period and count registers=0.
REQ-033 rst asserted mid-burst SHALL abort the burst immediately without a done pulse.
REQ-034 After rst is released, a new config SHALL be required before start has any effect.

Verification
REQ-035 Scenario: cfg period=4, count=3, then start -> ticks at cycles 4, 8 and 12 after start; done coincident with the third tick; busy low on the next cycle; ticks_left reads 3,2,1 then 3.
REQ-036 Scenario: period=1, count=0, start, then stop after 10 cycles -> tick high every RUN cycle, no tick in the stop cycle, no done, FSM in LOADED.
REQ-037 Scenario: start with no prior config after reset -> busy stays 0 and no tick for 100 cycles.
REQ-038 Scenario: period=6 running; stop asserted on a cycle where a tick is due -> tick suppressed; start and stop asserted together -> stays LOADED.
REQ-039 Scenario: cfg_valid held high during RUN -> cfg_ready=0 and nothing is accepted until the burst ends; the new config is accepted on the first LOADED cycle.
REQ-040 Scenario: rst pulsed asynchronously mid-burst (period=3, count=5) -> all outputs 0 at once, cfg_ready=1, no done.

Source files
------------

// File: rtl/tick_sequencer.sv
// tick_sequencer
//   Configurable periodic tick generator with finite or continuous bursts.
//   A config word (period, count) is accepted while not running. A start
//   request launches a burst that produces one tick every max(period,1)
//   cycles. A finite burst of N ticks ends with done on the Nth tick. A
//   continuous burst (count 0) runs until stop.
//
// Ports
//   clk         : clock, rising edge
//   rst         : asynchronous active-high reset
//   cfg_valid   : configuration word offered
//   cfg_ready   : configuration word can be accepted (not in RUN)
//   cfg_period  : tick period in clk cycles (0 treated as 1)
//   cfg_count   : ticks per burst, 0 = continuous
//   start       : level-sampled burst request
//   stop        : level-sampled abort request (wins over start)
//   tick        : one-cycle strobe, once per period
//   done        : one-cycle strobe coincident with the last tick of a burst
//   busy        : high while running
//   ticks_left  : ticks remaining in the current burst
module tick_sequencer #(
  parameter int DIV_WIDTH = 26,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [DIV_WIDTH-1:0] cfg_period,
  input  logic [CNT_WIDTH-1:0] cfg_count,
  input  logic                 start,
  input  logic                 stop,
  output logic                 tick,
  output logic                 done,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] ticks_left
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOADED = 2'd1,
    S_RUN    = 2'd2
  } state_t;

  state_t               state_q;
  logic [DIV_WIDTH-1:0] period_q;
  logic [CNT_WIDTH-1:0] count_q;
  logic [DIV_WIDTH-1:0] div_q;
  logic [CNT_WIDTH-1:0] ticks_left_q;
  logic                 tick_q;
  logic                 done_q;
  logic                 busy_q;
  logic                 cfg_ready_q;

  logic                 cfg_fire;
  logic [DIV_WIDTH-1:0] div_last;
  logic                 div_at_end;
  logic                 last_tick;

  // cfg_ready_q is registered from the next state, so it equals (state != RUN).
  assign cfg_fire = cfg_valid && cfg_ready_q;

  // A zero period behaves as period 1: the divider then sits at 0 and every
  // RUN cycle ends a period.
  always_comb begin
    div_last = '0;
    if (period_q != '0) div_last = period_q - DIV_WIDTH'(1);
  end

  assign div_at_end = (div_q == div_last);
  assign last_tick  = (count_q != '0) && (ticks_left_q == CNT_WIDTH'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      period_q     <= '0;
      count_q      <= '0;
      div_q        <= '0;
      ticks_left_q <= '0;
      tick_q       <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      cfg_ready_q  <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments throughout so every branch reads the
      // pre-edge register values, regardless of statement order.
      // NOTE: strobes default low here, so each branch only raises them.
      tick_q <= 1'b0;
      done_q <= 1'b0;

      unique case (state_q)
        S_IDLE: begin
          // start is ignored until a config has been taken.
          if (cfg_fire) begin
            period_q     <= cfg_period;
            count_q      <= cfg_count;
            ticks_left_q <= cfg_count;
            state_q      <= S_LOADED;
          end
        end

        S_LOADED: begin
          if (cfg_fire) begin
            period_q     <= cfg_period;
            count_q      <= cfg_count;
            ticks_left_q <= cfg_count;
          end
          if (start && !stop) begin
            state_q     <= S_RUN;
            div_q       <= '0;
            busy_q      <= 1'b1;
            cfg_ready_q <= 1'b0;
          end
        end

        S_RUN: begin
          if (stop) begin
            // Abort: any tick due this edge is dropped and no done is given.
            state_q      <= S_LOADED;
            div_q        <= '0;
            ticks_left_q <= count_q;
            busy_q       <= 1'b0;
            cfg_ready_q  <= 1'b1;
          end else if (div_at_end) begin
            tick_q <= 1'b1;
            div_q  <= '0;
            if (last_tick) begin
              done_q       <= 1'b1;
              state_q      <= S_LOADED;
              ticks_left_q <= count_q;
              busy_q       <= 1'b0;
              cfg_ready_q  <= 1'b1;
            end else if (count_q != '0) begin
              ticks_left_q <= ticks_left_q - CNT_WIDTH'(1);
            end
          end else begin
            div_q <= div_q + DIV_WIDTH'(1);
          end
        end

        default: begin
          state_q     <= S_IDLE;
          busy_q      <= 1'b0;
          cfg_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign tick       = tick_q;
  assign done       = done_q;
  assign busy       = busy_q;
  assign cfg_ready  = cfg_ready_q;
  assign ticks_left = ticks_left_q;

endmodule
